// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: handshaked pre-add / multiply / accumulate pipeline.
// Three register stages (operands, product, result) advance together on EN.
// EN is held low only while a result waits for the consumer, which makes the
// ready path a single gate and freezes the whole pipe on backpressure.
module dsp_mac_pipe #(
  parameter int A_WIDTH  = 18,
  parameter int B_WIDTH  = 18,
  parameter int P_WIDTH  = 48,
  parameter int PRE_ADD  = 1,
  parameter int SATURATE = 0,
  localparam int M_WIDTH = A_WIDTH + B_WIDTH + PRE_ADD
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic signed [A_WIDTH-1:0] A,
  input  logic signed [B_WIDTH-1:0] B,
  input  logic signed [B_WIDTH-1:0] D,
  input  logic signed [P_WIDTH-1:0] C,
  input  logic                      PRE_SUB,
  input  logic [1:0]                OPMODE,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic signed [P_WIDTH-1:0] P,
  output logic signed [M_WIDTH-1:0] M,
  output logic                      OVF
);

  localparam int BOP_W = B_WIDTH + PRE_ADD;
  // Two guard bits cover ACC +/- M and C + M without losing the true result.
  localparam int R_W   = P_WIDTH + 2;

  // True when R does not fit in signed P_WIDTH: guard bits and P sign bit disagree.
  function automatic logic f_ovf(input logic signed [R_W-1:0] r);
    return !((&r[R_W-1:P_WIDTH-1]) || !(|r[R_W-1:P_WIDTH-1]));
  endfunction

  // Clamp R to the signed P_WIDTH range.
  function automatic logic signed [P_WIDTH-1:0] f_sat(input logic signed [R_W-1:0] r);
    if (!f_ovf(r))  return r[P_WIDTH-1:0];
    else if (r[R_W-1]) return {1'b1, {(P_WIDTH-1){1'b0}}};
    else               return {1'b0, {(P_WIDTH-1){1'b1}}};
  endfunction

  logic w_en;
  assign w_en     = !OUT_VALID || OUT_READY;
  assign IN_READY = w_en;

  logic signed [B_WIDTH:0] w_d_ext, w_b_ext, w_pre;
  logic signed [BOP_W-1:0] w_bop;
  assign w_d_ext = (B_WIDTH+1)'(D);
  assign w_b_ext = (B_WIDTH+1)'(B);
  assign w_pre   = PRE_SUB ? (w_d_ext - w_b_ext) : (w_d_ext + w_b_ext);
  assign w_bop   = (PRE_ADD != 0) ? BOP_W'(w_pre) : BOP_W'(B);

  // ---- stage p0: operands, pre-adder result ----
  logic signed [A_WIDTH-1:0] r_a_p0;
  logic signed [BOP_W-1:0]   r_bop_p0;
  logic signed [P_WIDTH-1:0] r_c_p0;
  logic [1:0]                r_op_p0;
  logic                      r_vld_p0;

  // ---- stage p1: full-width product ----
  logic signed [M_WIDTH-1:0] r_m_p1;
  logic signed [P_WIDTH-1:0] r_c_p1;
  logic [1:0]                r_op_p1;
  logic                      r_vld_p1;

  logic signed [M_WIDTH-1:0] w_m_p0;
  assign w_m_p0 = M_WIDTH'(r_a_p0) * M_WIDTH'(r_bop_p0);

  // Stage valids: the only control state inside the pipe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
    end else if (w_en) begin
      r_vld_p0 <= IN_VALID;
      r_vld_p1 <= r_vld_p0;
    end
  end

  // Stage data: qualified by the travelling valids, so no reset needed.
  always_ff @(posedge CLK) begin
    if (w_en) begin
      r_a_p0   <= A;
      r_bop_p0 <= w_bop;
      r_c_p0   <= C;
      r_op_p0  <= OPMODE;
      r_m_p1   <= w_m_p0;
      r_c_p1   <= r_c_p0;
      r_op_p1  <= r_op_p0;
    end
  end

  // ---- stage p2: post-adder / accumulator, result registers ----
  logic signed [R_W-1:0]     w_m_ext, w_acc_ext, w_c_ext, w_r;
  logic signed [P_WIDTH-1:0] w_p_nxt;
  logic                      w_ovf;

  assign w_m_ext   = R_W'(r_m_p1);
  assign w_acc_ext = R_W'(P);
  assign w_c_ext   = R_W'(r_c_p1);

  // Post-adder select; the P register doubles as the accumulator.
  always_comb begin
    w_r = w_m_ext;
    case (r_op_p1)
      2'b01:   w_r = w_acc_ext + w_m_ext;
      2'b10:   w_r = w_acc_ext - w_m_ext;
      2'b11:   w_r = w_c_ext + w_m_ext;
      default: w_r = w_m_ext;
    endcase
  end

  assign w_ovf   = f_ovf(w_r);
  assign w_p_nxt = (SATURATE != 0) ? f_sat(w_r) : w_r[P_WIDTH-1:0];

  // Output registers: bubbles advance OUT_VALID but leave P/M/OVF untouched.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_VALID <= 1'b0;
      P         <= '0;
      M         <= '0;
      OVF       <= 1'b0;
    end else if (w_en) begin
      OUT_VALID <= r_vld_p1;
      if (r_vld_p1) begin
        P   <= w_p_nxt;
        M   <= r_m_p1;
        OVF <= w_ovf;
      end
    end
  end

endmodule
